// File: rtl/execute_mul_stage.sv
`default_nettype none
// ============================================================================
//  Module   : execute_mul_stage
//  Purpose  : LEGv8 execute stage with a single-cycle ALU, a branch-target
//             adder, an iterative shift-add multiplier (low N bits) with a
//             stall handshake and flush, and the EX/MEM pipeline register.
//  Revision : 1.0 - initial release
// ============================================================================
module execute_mul_stage #(
    parameter int N              = 64,
    parameter int MUL_EARLY_EXIT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         flush_E,
    input  logic         MulOp,
    input  logic         AluSrc,
    input  logic [3:0]   AluControl,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] signImm_E,
    input  logic [N-1:0] readData1_E,
    input  logic [N-1:0] readData2_E,
    output logic         stall_E,
    output logic         valid_M,
    output logic [N-1:0] PCBranch_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] writeData_M,
    output logic         zero_M
);

    localparam int         c_CNT_W    = $clog2(N + 1);
    localparam bit         c_EARLY    = (MUL_EARLY_EXIT != 0);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_MUL   = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [3:0] c_OP_AND   = 4'b0000;
    localparam logic [3:0] c_OP_OR    = 4'b0001;
    localparam logic [3:0] c_OP_ADD   = 4'b0010;
    localparam logic [3:0] c_OP_SUB   = 4'b0110;
    localparam logic [3:0] c_OP_PASSB = 4'b0111;
    localparam logic [3:0] c_OP_NOR   = 4'b1100;

    // Multiplier state
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [N-1:0]       r_mcand;
    logic [N-1:0]       r_mplier;
    logic [N-1:0]       r_acc;

    // EX/MEM register
    logic               r_valid_m;
    logic [N-1:0]       r_pcbranch_m;
    logic [N-1:0]       r_alu_m;
    logic [N-1:0]       r_wdata_m;
    logic               r_zero_m;

    logic [N-1:0]       w_opb;
    logic [N-1:0]       w_alu_result;
    logic               w_alu_zero;
    logic [N-1:0]       w_pcbranch;
    logic               w_mul_req;
    logic               w_stall;
    logic [N-1:0]       w_acc_step;
    logic [N-1:0]       w_mplier_shift;
    logic [c_CNT_W-1:0] w_cnt_dec;
    logic               w_mul_last;

    // Single-cycle ALU with operand-B select; SUB is A + ~B + 1
    always_comb begin
        w_opb        = AluSrc ? signImm_E : readData2_E;
        w_alu_result = '0;
        case (AluControl)
            c_OP_AND:   w_alu_result = readData1_E & w_opb;
            c_OP_OR:    w_alu_result = readData1_E | w_opb;
            c_OP_ADD:   w_alu_result = readData1_E + w_opb;
            c_OP_SUB:   w_alu_result = readData1_E + ~w_opb + {{(N-1){1'b0}}, 1'b1};
            c_OP_PASSB: w_alu_result = w_opb;
            c_OP_NOR:   w_alu_result = ~(readData1_E | w_opb);
            default:    w_alu_result = '0;
        endcase
        w_alu_zero = (w_alu_result == '0);
        w_pcbranch = PC_E + (signImm_E << 2);
    end

    // One shift-add step and its termination test
    always_comb begin
        w_acc_step     = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_mplier_shift = r_mplier >> 1;
        w_cnt_dec      = r_cnt - c_CNT_W'(1);
        w_mul_last     = (w_cnt_dec == '0) || (c_EARLY && (w_mplier_shift == '0));
    end

    // Stall: hold upstream while a multiply is being accepted or iterated
    always_comb begin
        w_mul_req = valid_E & MulOp;
        w_stall   = 1'b0;
        if (!reset && !flush_E) begin
            case (r_state)
                c_ST_IDLE: w_stall = w_mul_req;
                c_ST_MUL:  w_stall = 1'b1;
                default:   w_stall = 1'b0;
            endcase
        end
    end

    // Multiplier FSM and datapath; flush discards any multiply in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (flush_E) begin
            r_state  <= c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_mul_req) begin
                        r_mcand  <= readData1_E;
                        r_mplier <= readData2_E;
                        r_acc    <= '0;
                        r_cnt    <= c_CNT_W'(N);
                        r_state  <= c_ST_MUL;
                    end
                end
                c_ST_MUL: begin
                    r_acc    <= w_acc_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_shift;
                    r_cnt    <= w_cnt_dec;
                    if (w_mul_last) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    // EX/MEM register: ALU results in IDLE, product in DONE, bubbles otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_m    <= 1'b0;
            r_pcbranch_m <= '0;
            r_alu_m      <= '0;
            r_wdata_m    <= '0;
            r_zero_m     <= 1'b0;
        end else if (flush_E) begin
            r_valid_m    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_mul_req) begin
                        r_valid_m    <= 1'b0;
                    end else begin
                        r_valid_m    <= valid_E;
                        r_alu_m      <= w_alu_result;
                        r_zero_m     <= w_alu_zero;
                        r_pcbranch_m <= w_pcbranch;
                        r_wdata_m    <= readData2_E;
                    end
                end
                c_ST_DONE: begin
                    r_valid_m    <= 1'b1;
                    r_alu_m      <= r_acc;
                    r_zero_m     <= (r_acc == '0);
                    r_pcbranch_m <= w_pcbranch;
                    r_wdata_m    <= readData2_E;
                end
                default: r_valid_m <= 1'b0;
            endcase
        end
    end

    assign stall_E     = w_stall;
    assign valid_M     = r_valid_m;
    assign PCBranch_M  = r_pcbranch_m;
    assign aluResult_M = r_alu_m;
    assign writeData_M = r_wdata_m;
    assign zero_M      = r_zero_m;

endmodule
`default_nettype wire

// File: tb/tb_execute_mul_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute_mul_stage
//  Purpose  : Directed self-checking bench for execute_mul_stage, with one
//             early-exit instance and one full-width instance on shared inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_execute_mul_stage;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_E, flush_E, MulOp, AluSrc;
    logic [3:0]   AluControl;
    logic [N-1:0] PC_E, signImm_E, readData1_E, readData2_E;

    logic         ee_stall, ee_valid, ee_zero;
    logic [N-1:0] ee_pcb, ee_alu, ee_wd;
    logic         ne_stall, ne_valid, ne_zero;
    logic [N-1:0] ne_pcb, ne_alu, ne_wd;

    logic         sel_ne;
    logic         m_stall, m_valid, m_zero;
    logic [N-1:0] m_pcb, m_alu, m_wd;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    execute_mul_stage #(.N(N), .MUL_EARLY_EXIT(1)) dut_ee (
        .clk(clk), .reset(reset), .valid_E(valid_E), .flush_E(flush_E),
        .MulOp(MulOp), .AluSrc(AluSrc), .AluControl(AluControl),
        .PC_E(PC_E), .signImm_E(signImm_E), .readData1_E(readData1_E),
        .readData2_E(readData2_E), .stall_E(ee_stall), .valid_M(ee_valid),
        .PCBranch_M(ee_pcb), .aluResult_M(ee_alu), .writeData_M(ee_wd),
        .zero_M(ee_zero)
    );

    execute_mul_stage #(.N(N), .MUL_EARLY_EXIT(0)) dut_ne (
        .clk(clk), .reset(reset), .valid_E(valid_E), .flush_E(flush_E),
        .MulOp(MulOp), .AluSrc(AluSrc), .AluControl(AluControl),
        .PC_E(PC_E), .signImm_E(signImm_E), .readData1_E(readData1_E),
        .readData2_E(readData2_E), .stall_E(ne_stall), .valid_M(ne_valid),
        .PCBranch_M(ne_pcb), .aluResult_M(ne_alu), .writeData_M(ne_wd),
        .zero_M(ne_zero)
    );

    assign m_stall = sel_ne ? ne_stall : ee_stall;
    assign m_valid = sel_ne ? ne_valid : ee_valid;
    assign m_zero  = sel_ne ? ne_zero  : ee_zero;
    assign m_pcb   = sel_ne ? ne_pcb   : ee_pcb;
    assign m_alu   = sel_ne ? ne_alu   : ee_alu;
    assign m_wd    = sel_ne ? ne_wd    : ee_wd;

    typedef struct {
        logic [3:0]   ctl;
        logic         src;
        logic [N-1:0] a, b, imm, pc, res;
        logic         zero;
        logic [N-1:0] pcb;
    } alu_vec_t;

    task automatic idle_inputs();
        valid_E = 0; flush_E = 0; MulOp = 0; AluSrc = 0; AluControl = 4'b0010;
        PC_E = '0; signImm_E = '0; readData1_E = '0; readData2_E = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_inputs();
        valid_E = 1; MulOp = 1; readData1_E = 64'd3; readData2_E = 64'd4;
        PC_E = 64'h40; signImm_E = 64'h1;
        @(posedge clk); #1;
        total++; if (ee_stall !== 1'b0) $display("FAIL reset_stall_ee: got %b want 0", ee_stall); else passed++;
        total++; if (ne_stall !== 1'b0) $display("FAIL reset_stall_ne: got %b want 0", ne_stall); else passed++;
        total++; if (ee_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ee_valid); else passed++;
        total++; if (ee_alu !== '0) $display("FAIL reset_alu: got %h want 0", ee_alu); else passed++;
        total++; if (ee_pcb !== '0) $display("FAIL reset_pcb: got %h want 0", ee_pcb); else passed++;
        total++; if (ee_wd !== '0) $display("FAIL reset_wd: got %h want 0", ee_wd); else passed++;
        total++; if (ee_zero !== 1'b0) $display("FAIL reset_zero: got %b want 0", ee_zero); else passed++;
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_alu();
        alu_vec_t v[9];
        v[0] = '{4'b0010, 1'b0, 64'd5, 64'd7, 64'd4, 64'h100, 64'd12, 1'b0, 64'h110};
        v[1] = '{4'b0110, 1'b1, 64'd9, 64'h55, 64'd9, 64'h100, 64'd0, 1'b1, 64'h124};
        v[2] = '{4'b0000, 1'b0, 64'hF0F0, 64'hFF00, 64'd0, 64'd0, 64'hF000, 1'b0, 64'd0};
        v[3] = '{4'b0001, 1'b0, 64'hF0F0, 64'hFF00, 64'd0, 64'd0, 64'hFFF0, 1'b0, 64'd0};
        v[4] = '{4'b1100, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, {64{1'b1}}, 1'b0, 64'd0};
        v[5] = '{4'b0111, 1'b1, 64'h123, 64'd0, {64{1'b1}}, 64'h100, {64{1'b1}}, 1'b0, 64'hFC};
        v[6] = '{4'b0011, 1'b0, 64'd5, 64'd7, 64'd8, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 1'b1, 64'h10};
        v[7] = '{4'b0110, 1'b0, 64'd3, 64'd5, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'd0};
        v[8] = '{4'b0010, 1'b0, {64{1'b1}}, 64'd1, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0};
        sel_ne = 0;
        for (int i = 0; i < 9; i++) begin
            valid_E = 1; MulOp = 0; flush_E = 0;
            AluControl = v[i].ctl; AluSrc = v[i].src;
            readData1_E = v[i].a; readData2_E = v[i].b;
            signImm_E = v[i].imm; PC_E = v[i].pc;
            #1;
            total++; if (m_stall !== 1'b0) $display("FAIL alu%0d_stall: got %b want 0", i, m_stall); else passed++;
            @(posedge clk); #1;
            total++; if (m_alu !== v[i].res) $display("FAIL alu%0d_result: got %h want %h", i, m_alu, v[i].res); else passed++;
            total++; if (m_zero !== v[i].zero) $display("FAIL alu%0d_zero: got %b want %b", i, m_zero, v[i].zero); else passed++;
            total++; if (m_pcb !== v[i].pcb) $display("FAIL alu%0d_pcbranch: got %h want %h", i, m_pcb, v[i].pcb); else passed++;
            total++; if (m_wd !== v[i].b) $display("FAIL alu%0d_wdata: got %h want %h", i, m_wd, v[i].b); else passed++;
            total++; if (m_valid !== 1'b1) $display("FAIL alu%0d_valid: got %b want 1", i, m_valid); else passed++;
        end
        valid_E = 0;
        @(posedge clk); #1;
        total++; if (m_valid !== 1'b0) $display("FAIL alu_invalid_valid: got %b want 0", m_valid); else passed++;
    endtask

    task automatic run_mul(input logic sel, input logic [N-1:0] a, input logic [N-1:0] b,
                           input int exp_stall, input logic [N-1:0] exp_res);
        int  cnt;
        bit  bubble_bad;
        sel_ne = sel;
        valid_E = 1; MulOp = 1; flush_E = 0; AluSrc = 1; AluControl = 4'b0010;
        readData1_E = a; readData2_E = b; PC_E = 64'h200; signImm_E = 64'd1;
        cnt = 0; bubble_bad = 0;
        forever begin
            @(negedge clk);
            if (!m_stall || cnt >= 200) break;
            if (cnt > 0 && m_valid !== 1'b0) bubble_bad = 1;
            cnt++;
        end
        total++; if (cnt >= 200) $display("FAIL mul_timeout: stall still %b after %0d cycles", m_stall, cnt); else passed++;
        total++; if (cnt != exp_stall) $display("FAIL mul_stall_cycles: got %0d want %0d", cnt, exp_stall); else passed++;
        total++; if (bubble_bad) $display("FAIL mul_bubble: got valid_M=1 want 0 while stalled"); else passed++;
        @(posedge clk); #1;
        total++; if (m_alu !== exp_res) $display("FAIL mul_result: got %h want %h", m_alu, exp_res); else passed++;
        total++; if (m_zero !== (exp_res == '0)) $display("FAIL mul_zero: got %b want %b", m_zero, (exp_res == '0)); else passed++;
        total++; if (m_valid !== 1'b1) $display("FAIL mul_valid: got %b want 1", m_valid); else passed++;
        total++; if (m_pcb !== 64'h204) $display("FAIL mul_pcbranch: got %h want 204", m_pcb); else passed++;
        total++; if (m_wd !== b) $display("FAIL mul_wdata: got %h want %h", m_wd, b); else passed++;
    endtask

    task automatic test_mul();
        do_reset(); run_mul(1'b0, 64'd6, 64'd2, 3, 64'd12);
        do_reset(); run_mul(1'b1, {64{1'b1}}, 64'd3, 65, 64'hFFFF_FFFF_FFFF_FFFD);
        do_reset(); run_mul(1'b0, {64{1'b1}}, 64'd3, 3, 64'hFFFF_FFFF_FFFF_FFFD);
        do_reset(); run_mul(1'b0, 64'd5, 64'd0, 2, 64'd0);
        do_reset(); run_mul(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, 64'd6);
        do_reset(); run_mul(1'b0, 64'd1, 64'h8000_0000_0000_0000, 65, 64'h8000_0000_0000_0000);
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_mul(1'b0, 64'd6, 64'd2, 3, 64'd12);
        run_mul(1'b0, 64'd7, 64'd3, 3, 64'd21);
        valid_E = 0; MulOp = 0;
    endtask

    task automatic test_flush();
        do_reset();
        sel_ne = 1;
        valid_E = 1; MulOp = 1; readData1_E = {64{1'b1}}; readData2_E = {64{1'b1}};
        repeat (10) @(negedge clk);
        flush_E = 1;
        #1;
        total++; if (ne_stall !== 1'b0) $display("FAIL flush_stall_ne: got %b want 0", ne_stall); else passed++;
        total++; if (ee_stall !== 1'b0) $display("FAIL flush_stall_ee: got %b want 0", ee_stall); else passed++;
        @(posedge clk); #1;
        total++; if (ne_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", ne_valid); else passed++;
        flush_E = 0; MulOp = 0; AluSrc = 0; AluControl = 4'b0010;
        readData1_E = 64'd20; readData2_E = 64'd22;
        #1;
        total++; if (ne_stall !== 1'b0) $display("FAIL flush_next_stall: got %b want 0", ne_stall); else passed++;
        @(posedge clk); #1;
        total++; if (ne_alu !== 64'd42) $display("FAIL flush_next_add: got %h want 42", ne_alu); else passed++;
        total++; if (ne_valid !== 1'b1) $display("FAIL flush_next_valid: got %b want 1", ne_valid); else passed++;
        flush_E = 1;
        @(posedge clk); #1;
        total++; if (ne_valid !== 1'b0) $display("FAIL flush_idle_valid: got %b want 0", ne_valid); else passed++;
        flush_E = 0;
    endtask

    task automatic test_reset_mid_mul();
        sel_ne = 1;
        valid_E = 1; MulOp = 1; readData1_E = {64{1'b1}}; readData2_E = {64{1'b1}};
        repeat (5) @(negedge clk);
        reset = 1;
        #1;
        total++; if (ne_stall !== 1'b0) $display("FAIL rstmid_stall_now: got %b want 0", ne_stall); else passed++;
        @(posedge clk); #1;
        total++; if (ne_stall !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", ne_stall); else passed++;
        total++; if (ne_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", ne_valid); else passed++;
        total++; if (ne_alu !== '0) $display("FAIL rstmid_alu: got %h want 0", ne_alu); else passed++;
        total++; if (ne_pcb !== '0) $display("FAIL rstmid_pcb: got %h want 0", ne_pcb); else passed++;
        total++; if (ne_wd !== '0) $display("FAIL rstmid_wd: got %h want 0", ne_wd); else passed++;
        total++; if (ne_zero !== 1'b0) $display("FAIL rstmid_zero: got %b want 0", ne_zero); else passed++;
        reset = 0;
        run_mul(1'b1, 64'd3, 64'd5, 65, 64'd15);
        valid_E = 0; MulOp = 0;
    endtask

    initial begin
        sel_ne = 0;
        test_reset();
        test_alu();
        test_mul();
        test_back_to_back();
        test_flush();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
